// File: rtl/mux2by1_zero_case.sv
// Registered 64-bit add/subtract unit: a per-bit 2:1 mux picks B or ~B and a
// ripple-carry chain (carry-in = control) produces the result and NZCV-style flags.
module mux2by1_zero_case #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             control,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             overflow,
  output logic             carryOut,
  output logic             negative
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH:0]   carry;

  assign carry[0] = control;

  // carry[i+1] is the carry out of bit i, so carry[WIDTH] leaves the MSB.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign b_eff[i]   = control ? ~B[i] : B[i];
    assign sum[i]     = A[i] ^ b_eff[i] ^ carry[i];
    assign carry[i+1] = (A[i] & b_eff[i]) | (A[i] & carry[i]) | (b_eff[i] & carry[i]);
  end

  logic sum_zero;
  logic sum_overflow;
  logic sum_carry;
  logic sum_negative;

  assign sum_zero     = ~(|sum);
  assign sum_overflow = carry[WIDTH-1] ^ carry[WIDTH];
  assign sum_carry    = carry[WIDTH];
  assign sum_negative = sum[WIDTH-1];

  // Result and flags share one register stage so they always describe the same operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out      <= '0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      carryOut <= 1'b0;
      negative <= 1'b0;
    end else begin
      out      <= sum;
      zero     <= sum_zero;
      overflow <= sum_overflow;
      carryOut <= sum_carry;
      negative <= sum_negative;
    end
  end

endmodule

// File: tb/tb_mux2by1_zero_case.sv
// Directed-vector bench for mux2by1_zero_case: add, subtract, overflow corners,
// back-to-back issue and asynchronous reset behaviour.
module tb_mux2by1_zero_case;

  localparam int W = 64;

  logic         clk;
  logic         reset;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         control;
  logic [W-1:0] out;
  logic         zero;
  logic         overflow;
  logic         carry_out;
  logic         negative;

  int tests_run;
  int tests_failed;

  mux2by1_zero_case #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .A        (a),
    .B        (b),
    .control  (control),
    .out      (out),
    .zero     (zero),
    .overflow (overflow),
    .carryOut (carry_out),
    .negative (negative)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags packed as {zero, overflow, carryOut, negative}
  function automatic logic [3:0] flags_now();
    return {zero, overflow, carry_out, negative};
  endfunction

  // Drive operands at the falling edge, then sample just after the next rising edge.
  task automatic apply_op(input logic ctl, input logic [W-1:0] op_a, input logic [W-1:0] op_b);
    @(negedge clk);
    control = ctl;
    a       = op_a;
    b       = op_b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    control = 1'b0;
    a       = 64'd7;
    b       = 64'd9;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (out !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_out: got %h expected %h", out, 64'd0);
    end
    tests_run++;
    if (flags_now() !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_flags: got %b expected %b", flags_now(), 4'b0000);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_add();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] vr [4];
    logic [3:0]   vf [4];
    va[0] = 64'd2;   vb[0] = 64'd3;   vr[0] = 64'd5;   vf[0] = 4'b0000;
    va[1] = 64'd255; vb[1] = 64'd256; vr[1] = 64'd511; vf[1] = 4'b0000;
    va[2] = 64'd15;  vb[2] = 64'd15;  vr[2] = 64'd30;  vf[2] = 4'b0000;
    va[3] = 64'hFFFF_FFFF_FFFF_FFFF; vb[3] = 64'd1; vr[3] = 64'd0; vf[3] = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      apply_op(1'b0, va[i], vb[i]);
      tests_run++;
      if (out !== vr[i]) begin
        tests_failed++;
        $display("FAIL add_out[%0d]: got %h expected %h", i, out, vr[i]);
      end
      tests_run++;
      if (flags_now() !== vf[i]) begin
        tests_failed++;
        $display("FAIL add_flags[%0d]: got %b expected %b", i, flags_now(), vf[i]);
      end
    end
  endtask

  task automatic test_sub();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic [W-1:0] vr [4];
    logic [3:0]   vf [4];
    va[0] = 64'd1;  vb[0] = 64'd1; vr[0] = 64'd0;                  vf[0] = 4'b1010;
    va[1] = 64'd0;  vb[1] = 64'd1; vr[1] = 64'hFFFF_FFFF_FFFF_FFFF; vf[1] = 4'b0001;
    va[2] = 64'd10; vb[2] = 64'd3; vr[2] = 64'd7;                  vf[2] = 4'b0010;
    va[3] = 64'd3;  vb[3] = 64'd10; vr[3] = 64'hFFFF_FFFF_FFFF_FFF9; vf[3] = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      apply_op(1'b1, va[i], vb[i]);
      tests_run++;
      if (out !== vr[i]) begin
        tests_failed++;
        $display("FAIL sub_out[%0d]: got %h expected %h", i, out, vr[i]);
      end
      tests_run++;
      if (flags_now() !== vf[i]) begin
        tests_failed++;
        $display("FAIL sub_flags[%0d]: got %b expected %b", i, flags_now(), vf[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic         vc [3];
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic [W-1:0] vr [3];
    logic [3:0]   vf [3];
    vc[0] = 1'b0; va[0] = 64'h8000_0000_0000_0000; vb[0] = 64'h8000_0000_0000_0000;
    vr[0] = 64'd0; vf[0] = 4'b1110;
    vc[1] = 1'b0; va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = 64'd1;
    vr[1] = 64'h8000_0000_0000_0000; vf[1] = 4'b0101;
    vc[2] = 1'b1; va[2] = 64'h8000_0000_0000_0000; vb[2] = 64'd1;
    vr[2] = 64'h7FFF_FFFF_FFFF_FFFF; vf[2] = 4'b0110;
    for (int i = 0; i < 3; i++) begin
      apply_op(vc[i], va[i], vb[i]);
      tests_run++;
      if (out !== vr[i]) begin
        tests_failed++;
        $display("FAIL ovf_out[%0d]: got %h expected %h", i, out, vr[i]);
      end
      tests_run++;
      if (flags_now() !== vf[i]) begin
        tests_failed++;
        $display("FAIL ovf_flags[%0d]: got %b expected %b", i, flags_now(), vf[i]);
      end
    end
  endtask

  // New operands each cycle; outputs must still show the previous result until the edge.
  task automatic test_back_to_back();
    logic [W-1:0] prev;
    apply_op(1'b0, 64'd100, 64'd23);
    prev = 64'd123;
    for (int i = 0; i < 5; i++) begin
      logic [W-1:0] exp_v;
      @(negedge clk);
      control = i[0];
      a       = 64'd1000 + 64'(i);
      b       = 64'd10 * 64'(i);
      exp_v   = control ? (64'd1000 + 64'(i) - 64'd10 * 64'(i))
                        : (64'd1000 + 64'(i) + 64'd10 * 64'(i));
      #1;
      tests_run++;
      if (out !== prev) begin
        tests_failed++;
        $display("FAIL b2b_hold[%0d]: got %h expected %h", i, out, prev);
      end
      @(posedge clk);
      #1;
      tests_run++;
      if (out !== exp_v) begin
        tests_failed++;
        $display("FAIL b2b_out[%0d]: got %h expected %h", i, out, exp_v);
      end
      prev = exp_v;
    end
  endtask

  task automatic test_mid_reset();
    apply_op(1'b1, 64'd0, 64'd1);
    #2;
    reset = 1'b0;
    #1;
    tests_run++;
    if (out !== 64'd0) begin
      tests_failed++;
      $display("FAIL mid_reset_out: got %h expected %h", out, 64'd0);
    end
    tests_run++;
    if (flags_now() !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mid_reset_flags: got %b expected %b", flags_now(), 4'b0000);
    end
    @(negedge clk);
    control = 1'b0;
    a       = 64'd40;
    b       = 64'd2;
    @(posedge clk);
    #1;
    tests_run++;
    if (out !== 64'd0) begin
      tests_failed++;
      $display("FAIL reset_held_out: got %h expected %h", out, 64'd0);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++;
    if (out !== 64'd0) begin
      tests_failed++;
      $display("FAIL release_no_update: got %h expected %h", out, 64'd0);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (out !== 64'd42) begin
      tests_failed++;
      $display("FAIL post_reset_out: got %h expected %h", out, 64'd42);
    end
    tests_run++;
    if (flags_now() !== 4'b0000) begin
      tests_failed++;
      $display("FAIL post_reset_flags: got %b expected %b", flags_now(), 4'b0000);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
